// File: rtl/eth_miim_pkg.sv
// rtl/eth_miim_pkg.sv - shared types and constants for the clause-22 management responder
package eth_miim_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ST,
        OP,
        PHYAD,
        REGAD,
        TA,
        DATA,
        ABORT
    } miim_state_t;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    localparam int PHYAD_W = 5;
    localparam int REGAD_W = 5;
    localparam int DATA_W  = 16;

endpackage

// File: rtl/eth_miim_sync_edge.sv
// rtl/eth_miim_sync_edge.sv - multi-stage synchronizer with rise/fall pulse outputs
module eth_miim_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    // Shift the asynchronous input through the synchronizer chain, then keep one history flop
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign sync_out = sync_q[STAGES-1];
    assign rise     = sync_out & ~hist_q;
    assign fall     = ~sync_out & hist_q;

endmodule

// File: rtl/eth_miim_responder.sv
// rtl/eth_miim_responder.sv - PHY-side MDC/MDIO clause-22 frame responder
module eth_miim_responder
    import eth_miim_pkg::*;
#(
    parameter int PREAMBLE_LEN = 32,
    parameter int SYNC_STAGES  = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [PHYAD_W-1:0] PhyAddr,
    input  logic               Mdc,
    input  logic               MdiIn,
    output logic               Mdo,
    output logic               MdoEn,
    output logic [REGAD_W-1:0] RegAddr,
    output logic [DATA_W-1:0]  RegWrData,
    output logic               RegWrStb,
    output logic               RegRdStb,
    input  logic [DATA_W-1:0]  RegRdData,
    output logic               Busy
);

    localparam int               PRE_W    = $clog2(PREAMBLE_LEN + 1);
    localparam logic [PRE_W-1:0] PRE_FULL = PRE_W'(PREAMBLE_LEN);

    logic mdc_rise;
    logic mdc_fall;
    logic mdc_level_unused;
    logic mdi;
    logic mdi_rise_unused;
    logic mdi_fall_unused;

    miim_state_t        state, state_nxt;
    logic [3:0]         bit_cnt, bit_cnt_nxt;
    logic [PRE_W-1:0]   pre_cnt, pre_cnt_nxt;
    logic [DATA_W-1:0]  shreg, shreg_nxt;
    logic               is_rd, is_rd_nxt;
    logic               addr_ok, addr_ok_nxt;
    logic               rd_latch, rd_latch_nxt;
    logic               mdo_nxt, mdo_en_nxt;
    logic [REGAD_W-1:0] reg_addr_nxt;
    logic [DATA_W-1:0]  wr_data_nxt;
    logic               wr_stb_nxt, rd_stb_nxt, busy_nxt;
    logic [DATA_W-1:0]  shift_in;

    eth_miim_sync_edge #(.STAGES(SYNC_STAGES)) u_mdc_sync (
        .Clk      (Clk),
        .Reset    (Reset),
        .async_in (Mdc),
        .sync_out (mdc_level_unused),
        .rise     (mdc_rise),
        .fall     (mdc_fall)
    );

    // MdiIn passes through the same depth so each sample lines up with its Mdc rise
    eth_miim_sync_edge #(.STAGES(SYNC_STAGES)) u_mdi_sync (
        .Clk      (Clk),
        .Reset    (Reset),
        .async_in (MdiIn),
        .sync_out (mdi),
        .rise     (mdi_rise_unused),
        .fall     (mdi_fall_unused)
    );

    assign shift_in = {shreg[DATA_W-2:0], mdi};

    // Frame decode: fields advance on Mdc rises, MDIO drive changes on Mdc falls
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        pre_cnt_nxt  = pre_cnt;
        shreg_nxt    = shreg;
        is_rd_nxt    = is_rd;
        addr_ok_nxt  = addr_ok;
        rd_latch_nxt = RegRdStb;
        mdo_nxt      = Mdo;
        mdo_en_nxt   = MdoEn;
        reg_addr_nxt = RegAddr;
        wr_data_nxt  = RegWrData;
        wr_stb_nxt   = 1'b0;
        rd_stb_nxt   = 1'b0;
        busy_nxt     = Busy;

        case (state)
            IDLE: begin
                if (mdc_rise) begin
                    if (mdi) begin
                        if (pre_cnt != PRE_FULL) pre_cnt_nxt = pre_cnt + 1'b1;
                    end else if (pre_cnt == PRE_FULL) begin
                        state_nxt   = ST;
                        busy_nxt    = 1'b1;
                        pre_cnt_nxt = '0;
                    end else begin
                        pre_cnt_nxt = '0;
                    end
                end
                // Release the line one fall after the last read data bit
                if (mdc_fall) begin
                    mdo_en_nxt = 1'b0;
                    mdo_nxt    = 1'b0;
                end
            end
            ST: begin
                if (mdc_rise) begin
                    if (mdi) begin
                        state_nxt   = OP;
                        bit_cnt_nxt = 4'd1;
                    end else begin
                        state_nxt   = ABORT;
                        busy_nxt    = 1'b0;
                        pre_cnt_nxt = '0;
                    end
                end
            end
            OP: begin
                if (mdc_rise) begin
                    shreg_nxt = shift_in;
                    if (bit_cnt != 4'd0) begin
                        bit_cnt_nxt = bit_cnt - 4'd1;
                    end else if (shift_in[1:0] == OP_READ || shift_in[1:0] == OP_WRITE) begin
                        is_rd_nxt   = (shift_in[1:0] == OP_READ);
                        state_nxt   = PHYAD;
                        bit_cnt_nxt = 4'(PHYAD_W - 1);
                    end else begin
                        state_nxt   = ABORT;
                        busy_nxt    = 1'b0;
                        pre_cnt_nxt = '0;
                    end
                end
            end
            PHYAD: begin
                // A mismatch is only remembered; the frame is still walked to its end
                if (mdc_rise) begin
                    shreg_nxt = shift_in;
                    if (bit_cnt != 4'd0) begin
                        bit_cnt_nxt = bit_cnt - 4'd1;
                    end else begin
                        addr_ok_nxt = (shift_in[PHYAD_W-1:0] == PhyAddr);
                        state_nxt   = REGAD;
                        bit_cnt_nxt = 4'(REGAD_W - 1);
                    end
                end
            end
            REGAD: begin
                if (mdc_rise) begin
                    shreg_nxt = shift_in;
                    if (bit_cnt != 4'd0) begin
                        bit_cnt_nxt = bit_cnt - 4'd1;
                    end else begin
                        if (addr_ok) begin
                            reg_addr_nxt = shift_in[REGAD_W-1:0];
                            rd_stb_nxt   = is_rd;
                        end
                        state_nxt   = TA;
                        bit_cnt_nxt = 4'd1;
                    end
                end
            end
            TA: begin
                if (mdc_rise) begin
                    if (bit_cnt != 4'd0) begin
                        bit_cnt_nxt = bit_cnt - 4'd1;
                    end else begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = 4'(DATA_W - 1);
                    end
                end
                // The fall after the first TA sample opens the second TA bit with a driven 0
                if (mdc_fall && bit_cnt == 4'd0 && is_rd && addr_ok) begin
                    mdo_en_nxt = 1'b1;
                    mdo_nxt    = 1'b0;
                end
            end
            DATA: begin
                if (mdc_rise) begin
                    if (!is_rd) shreg_nxt = shift_in;
                    if (bit_cnt != 4'd0) begin
                        bit_cnt_nxt = bit_cnt - 4'd1;
                    end else begin
                        if (!is_rd && addr_ok) begin
                            wr_data_nxt = shift_in;
                            wr_stb_nxt  = 1'b1;
                        end
                        state_nxt   = IDLE;
                        pre_cnt_nxt = '0;
                        busy_nxt    = 1'b0;
                    end
                end
                if (mdc_fall && is_rd && addr_ok) begin
                    mdo_nxt   = shreg[DATA_W-1];
                    shreg_nxt = {shreg[DATA_W-2:0], 1'b0};
                end
            end
            ABORT: begin
                state_nxt   = IDLE;
                busy_nxt    = 1'b0;
                pre_cnt_nxt = '0;
                mdo_en_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Read data is captured the Clk after the strobe, well before the first drive fall
        if (rd_latch) shreg_nxt = RegRdData;
    end

    // State and output registers; Reset clears the drive enable immediately
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            pre_cnt   <= '0;
            shreg     <= '0;
            is_rd     <= 1'b0;
            addr_ok   <= 1'b0;
            rd_latch  <= 1'b0;
            Mdo       <= 1'b0;
            MdoEn     <= 1'b0;
            RegAddr   <= '0;
            RegWrData <= '0;
            RegWrStb  <= 1'b0;
            RegRdStb  <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            pre_cnt   <= pre_cnt_nxt;
            shreg     <= shreg_nxt;
            is_rd     <= is_rd_nxt;
            addr_ok   <= addr_ok_nxt;
            rd_latch  <= rd_latch_nxt;
            Mdo       <= mdo_nxt;
            MdoEn     <= mdo_en_nxt;
            RegAddr   <= reg_addr_nxt;
            RegWrData <= wr_data_nxt;
            RegWrStb  <= wr_stb_nxt;
            RegRdStb  <= rd_stb_nxt;
            Busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_eth_miim_responder.sv
// tb/tb_eth_miim_responder.sv - self-checking bench for the MDC/MDIO responder
module tb_eth_miim_responder;

    localparam int PRE_LEN = 32;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [4:0]  PhyAddr = 5'h03;
    logic        Mdc = 1'b0;
    logic        MdiIn = 1'b1;
    logic [15:0] RegRdData = 16'h0000;
    logic        Mdo;
    logic        MdoEn;
    logic [4:0]  RegAddr;
    logic [15:0] RegWrData;
    logic        RegWrStb;
    logic        RegRdStb;
    logic        Busy;

    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [4:0]  wr_addr_cap = '0;
    logic [4:0]  rd_addr_cap = '0;
    logic [15:0] wr_data_cap = '0;
    logic [4:0]  exp_regaddr = '0;

    eth_miim_responder #(.PREAMBLE_LEN(PRE_LEN), .SYNC_STAGES(2)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .PhyAddr   (PhyAddr),
        .Mdc       (Mdc),
        .MdiIn     (MdiIn),
        .Mdo       (Mdo),
        .MdoEn     (MdoEn),
        .RegAddr   (RegAddr),
        .RegWrData (RegWrData),
        .RegWrStb  (RegWrStb),
        .RegRdStb  (RegRdStb),
        .RegRdData (RegRdData),
        .Busy      (Busy)
    );

    always #5 Clk = ~Clk;

    // Strobe monitor, sampled on the falling Clk edge
    always @(negedge Clk) begin
        if (RegWrStb === 1'b1) begin
            wr_cnt      <= wr_cnt + 1;
            wr_addr_cap <= RegAddr;
            wr_data_cap <= RegWrData;
        end
        if (RegRdStb === 1'b1) begin
            rd_cnt      <= rd_cnt + 1;
            rd_addr_cap <= RegAddr;
        end
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Master side: optional 0 separator, pre_len ones, then ST OP PHYAD REGAD TA DATA.
    // rst_bit >= 0 pulses Reset at the rise of that read data bit and abandons the frame.
    task automatic send_frame(input int pre_len, input bit st, input logic [1:0] op,
                              input logic [4:0] phy, input logic [4:0] regad,
                              input logic [15:0] data, input int h, input int rst_bit,
                              input bit sep);
        logic [79:0] bits, en_obs, mdo_obs, busy_obs, en_exp, mdo_exp, busy_exp;
        int          off, s, n, end_k, wr0, rd0;
        bit          acc, op_ok, match, exp_wr, exp_rd;

        bits = '0; en_obs = '0; mdo_obs = '0; busy_obs = '0;
        en_exp = '0; mdo_exp = '0; busy_exp = '0;
        off = sep ? 1 : 0;
        s   = off + pre_len;
        n   = s + 32;
        for (int k = off; k < s; k++) bits[k] = 1'b1;
        bits[s]   = 1'b0;
        bits[s+1] = st;
        bits[s+2] = op[1];
        bits[s+3] = op[0];
        for (int i = 0; i < 5; i++) begin
            bits[s+4+i] = phy[4-i];
            bits[s+9+i] = regad[4-i];
        end
        bits[s+14] = 1'b1;
        bits[s+15] = 1'b0;
        for (int i = 0; i < 16; i++)
            bits[s+16+i] = (op == 2'b10) ? 1'($urandom) : data[15-i];
        RegRdData = data;

        // Reference expectations from the frame rules
        acc    = (pre_len >= PRE_LEN);
        op_ok  = (op == 2'b10) || (op == 2'b01);
        end_k  = !st ? s + 1 : (!op_ok ? s + 3 : s + 31);
        if (acc) for (int k = s + 1; k <= end_k; k++) busy_exp[k] = 1'b1;
        match  = acc && st && op_ok && (phy == PhyAddr);
        exp_wr = match && (op == 2'b01);
        exp_rd = match && (op == 2'b10);
        if (exp_rd) begin
            en_exp[s+15] = 1'b1;
            for (int i = 0; i < 16; i++) begin
                en_exp[s+16+i]  = 1'b1;
                mdo_exp[s+16+i] = data[15-i];
            end
        end
        wr0 = wr_cnt;
        rd0 = rd_cnt;

        for (int k = 0; k < n; k++) begin
            MdiIn = bits[k];
            repeat (h) @(negedge Clk);
            en_obs[k]   = MdoEn;
            mdo_obs[k]  = Mdo;
            busy_obs[k] = Busy;
            Mdc = 1'b1;
            if (rst_bit >= 0 && k == s + 31 - rst_bit) begin
                repeat (2) @(negedge Clk);
                check("pre_reset_mdoen", 80'(MdoEn), 80'(1));
                Reset = 1'b1;
                #1;
                check("reset_mid_frame_outputs",
                      80'({Mdo, MdoEn, RegAddr, RegWrData, RegWrStb, RegRdStb, Busy}), 80'(0));
                @(negedge Clk);
                Reset = 1'b0;
                Mdc = 1'b0;
                exp_regaddr = '0;
                repeat (2 * h) @(negedge Clk);
                return;
            end
            repeat (h) @(negedge Clk);
            Mdc = 1'b0;
        end
        repeat (h + 3) @(negedge Clk);

        check("wr_stb_count", 80'(wr_cnt - wr0), 80'(exp_wr));
        check("rd_stb_count", 80'(rd_cnt - rd0), 80'(exp_rd));
        if (exp_wr) begin
            check("wr_data", 80'(wr_data_cap), 80'(data));
            check("wr_addr", 80'(wr_addr_cap), 80'(regad));
        end
        if (exp_rd) check("rd_addr", 80'(rd_addr_cap), 80'(regad));
        if (match) exp_regaddr = regad;
        check("reg_addr", 80'(RegAddr), 80'(exp_regaddr));
        check("mdoen_profile", en_obs, en_exp);
        check("mdo_profile", mdo_obs & en_exp, mdo_exp);
        check("busy_profile", busy_obs, busy_exp);
        check("idle_after_frame", 80'({Busy, MdoEn}), 80'(0));
    endtask

    initial begin
        int          pre, h, op_r;
        logic [1:0]  op;
        logic [4:0]  phy;
        bit          st;

        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        check("reset_outputs",
              80'({Mdo, MdoEn, RegAddr, RegWrData, RegWrStb, RegRdStb, Busy}), 80'(0));
        Reset = 1'b0;
        repeat (4) @(negedge Clk);

        // Directed cases
        PhyAddr = 5'h03;
        send_frame(32, 1'b1, 2'b01, 5'h03, 5'h04, 16'hA5C3, 4, -1, 1'b1);
        send_frame(32, 1'b1, 2'b10, 5'h03, 5'h09, 16'h1234, 4, -1, 1'b1);
        send_frame(32, 1'b1, 2'b10, 5'h07, 5'h0C, 16'hBEEF, 5, -1, 1'b1);
        send_frame(32, 1'b1, 2'b01, 5'h03, 5'h11, 16'h0F0F, 4, -1, 1'b1);
        send_frame(31, 1'b1, 2'b01, 5'h03, 5'h05, 16'h5555, 4, -1, 1'b1);
        send_frame(32, 1'b1, 2'b01, 5'h03, 5'h05, 16'h5555, 4, -1, 1'b1);
        send_frame(32, 1'b1, 2'b11, 5'h03, 5'h06, 16'hFFFF, 4, -1, 1'b1);
        send_frame(32, 1'b1, 2'b00, 5'h03, 5'h06, 16'h0000, 4, -1, 1'b1);
        send_frame(32, 1'b0, 2'b01, 5'h03, 5'h06, 16'h1111, 4, -1, 1'b1);
        send_frame(32, 1'b1, 2'b10, 5'h03, 5'h0B, 16'hC3A5, 4, 8, 1'b1);
        send_frame(32, 1'b1, 2'b10, 5'h03, 5'h1F, 16'h8001, 4, -1, 1'b1);
        send_frame(40, 1'b1, 2'b01, 5'h03, 5'h02, 16'hFFFF, 6, -1, 1'b1);
        send_frame(32, 1'b1, 2'b01, 5'h03, 5'h13, 16'h7E81, 4, -1, 1'b0);
        send_frame(31, 1'b1, 2'b01, 5'h03, 5'h14, 16'h3C3C, 4, -1, 1'b0);

        // Randomized frames
        for (int f = 0; f < 16; f++) begin
            PhyAddr = 5'($urandom);
            pre  = $urandom_range(30, 36);
            h    = $urandom_range(4, 7);
            st   = ($urandom_range(0, 7) != 0);
            op_r = $urandom_range(0, 5);
            op   = (op_r < 2) ? 2'b10 : ((op_r < 4) ? 2'b01 : 2'($urandom));
            phy  = ($urandom_range(0, 2) == 0) ? 5'($urandom) : PhyAddr;
            send_frame(pre, st, op, phy, 5'($urandom), 16'($urandom), h, -1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
